// File: rtl/basic_alu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : basic_alu_pkg
// Brief    : Opcode encoding and shared helpers for the basic_alu datapath.
// Revision : 1.0 - initial release
// ============================================================================
package basic_alu_pkg;

  localparam int ALU_OP_W = 3;

  typedef enum logic [ALU_OP_W-1:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_AND  = 3'b010,
    OP_OR   = 3'b011,
    OP_NOTA = 3'b100,
    OP_NOTB = 3'b101,
    OP_XOR  = 3'b110,
    OP_XNOR = 3'b111
  } alu_op_e;

  // Only ADD and SUB produce meaningful carry/overflow; logic ops force them to 0.
  function automatic logic is_arith(input alu_op_e op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage
`default_nettype wire

// File: rtl/basic_alu_core.sv
`default_nettype none
// ============================================================================
// Module   : basic_alu_core
// Brief    : Combinational WIDTH-bit ALU: result plus carry/borrow and overflow.
// Revision : 1.0 - initial release
// ============================================================================
module basic_alu_core
  import basic_alu_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0]    A,
  input  logic [WIDTH-1:0]    B,
  input  logic [ALU_OP_W-1:0] op,
  output logic [WIDTH-1:0]    result,
  output logic                carry,
  output logic                overflow
);

  localparam int c_msb = WIDTH - 1;

  alu_op_e          w_op;
  logic [WIDTH:0]   w_add_sum;
  logic [WIDTH:0]   w_sub_diff;
  logic [WIDTH-1:0] w_and;
  logic [WIDTH-1:0] w_or;
  logic [WIDTH-1:0] w_xor;
  logic             w_add_ovf;
  logic             w_sub_ovf;

  assign w_op = alu_op_e'(op);

  // Subtraction as A + ~B + 1 so bit WIDTH is the inverted borrow.
  assign w_add_sum  = {1'b0, A} + {1'b0, B};
  assign w_sub_diff = {1'b0, A} + {1'b0, ~B} + {{WIDTH{1'b0}}, 1'b1};

  assign w_add_ovf = (A[c_msb] == B[c_msb]) && (w_add_sum[c_msb]  != A[c_msb]);
  assign w_sub_ovf = (A[c_msb] != B[c_msb]) && (w_sub_diff[c_msb] != A[c_msb]);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign w_and[i] = A[i] & B[i];
    assign w_or[i]  = A[i] | B[i];
    assign w_xor[i] = A[i] ^ B[i];
  end

  always_comb begin
    result   = '0;
    carry    = 1'b0;
    overflow = 1'b0;
    case (w_op)
      OP_ADD: begin
        result   = w_add_sum[WIDTH-1:0];
        carry    = w_add_sum[WIDTH];
        overflow = w_add_ovf;
      end
      OP_SUB: begin
        result   = w_sub_diff[WIDTH-1:0];
        carry    = ~w_sub_diff[WIDTH];
        overflow = w_sub_ovf;
      end
      OP_AND:  result = w_and;
      OP_OR:   result = w_or;
      OP_NOTA: result = ~A;
      OP_NOTB: result = ~B;
      OP_XOR:  result = w_xor;
      OP_XNOR: result = ~w_xor;
      default: result = '0;
    endcase
    if (!is_arith(w_op)) begin
      carry    = 1'b0;
      overflow = 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/basic_alu.sv
`default_nettype none
// ============================================================================
// Module   : basic_alu
// Brief    : Registered 8-function ALU with status flags and 1-cycle valid pipe.
// Revision : 1.0 - initial release
// ============================================================================
module basic_alu
  import basic_alu_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  input  logic [WIDTH-1:0]    A,
  input  logic [WIDTH-1:0]    B,
  input  logic [ALU_OP_W-1:0] op,
  output logic [WIDTH-1:0]    alu_out,
  output logic                out_valid,
  output logic                carry,
  output logic                overflow,
  output logic                zero,
  output logic                negative
);

  logic [WIDTH-1:0] w_result;
  logic             w_carry;
  logic             w_overflow;

  logic [WIDTH-1:0] r_alu_out;
  logic             r_out_valid;
  logic             r_carry;
  logic             r_overflow;

  basic_alu_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .A        (A),
    .B        (B),
    .op       (op),
    .result   (w_result),
    .carry    (w_carry),
    .overflow (w_overflow)
  );

  // Result and flags hold when no new operands arrive; only out_valid drops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_alu_out   <= '0;
      r_out_valid <= 1'b0;
      r_carry     <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_out_valid <= in_valid;
      if (in_valid) begin
        r_alu_out  <= w_result;
        r_carry    <= w_carry;
        r_overflow <= w_overflow;
      end
    end
  end

  // zero/negative follow the registered result, so reset yields zero=1 for free.
  assign alu_out   = r_alu_out;
  assign out_valid = r_out_valid;
  assign carry     = r_carry;
  assign overflow  = r_overflow;
  assign zero      = (r_alu_out == '0);
  assign negative  = r_alu_out[WIDTH-1];

endmodule
`default_nettype wire

// File: tb/tb_basic_alu.sv
`default_nettype none
// ============================================================================
// Module   : tb_basic_alu
// Brief    : Directed and randomised self-checking bench for basic_alu (WIDTH=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_basic_alu;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [3:0] A;
  logic [3:0] B;
  logic [2:0] op;
  logic [3:0] alu_out;
  logic       out_valid;
  logic       carry;
  logic       overflow;
  logic       zero;
  logic       negative;

  int n_tests = 0;
  int n_fail  = 0;

  basic_alu #(
    .WIDTH (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .A         (A),
    .B         (B),
    .op        (op),
    .alu_out   (alu_out),
    .out_valid (out_valid),
    .carry     (carry),
    .overflow  (overflow),
    .zero      (zero),
    .negative  (negative)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // Observed vector layout: {out_valid, carry, overflow, zero, negative, alu_out}
  function automatic logic [8:0] obs();
    return {out_valid, carry, overflow, zero, negative, alu_out};
  endfunction

  task automatic check(input string tag, input logic [8:0] got, input logic [8:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %09b expected %09b", tag, got, exp);
    end
  endtask

  // Apply inputs on the falling edge, return 1 time unit after the next rising edge.
  task automatic drive(input logic v, input logic [3:0] a, input logic [3:0] b, input logic [2:0] o);
    @(negedge clk);
    in_valid = v;
    A        = a;
    B        = b;
    op       = o;
    @(posedge clk);
    #1;
  endtask

  // Independent reference: integer arithmetic, signed range check for overflow.
  function automatic logic [5:0] model(input logic [3:0] a, input logic [3:0] b, input logic [2:0] o);
    int ua, ub, sa, sb, r, s;
    logic c, v;
    logic [3:0] res;
    ua = int'(a);
    ub = int'(b);
    sa = (ua >= 8) ? ua - 16 : ua;
    sb = (ub >= 8) ? ub - 16 : ub;
    c = 1'b0;
    v = 1'b0;
    r = 0;
    case (o)
      3'd0: begin r = ua + ub;      c = (r > 15);  s = sa + sb; v = (s > 7) || (s < -8); end
      3'd1: begin r = ua - ub + 16; c = (ua < ub); s = sa - sb; v = (s > 7) || (s < -8); end
      3'd2: r = int'(a & b);
      3'd3: r = int'(a | b);
      3'd4: r = 15 - ua;
      3'd5: r = 15 - ub;
      3'd6: r = int'(a ^ b);
      default: r = 15 - int'(a ^ b);
    endcase
    res = r[3:0];
    return {c, v, res};
  endfunction

  initial begin
    logic [8:0] held;
    logic [5:0] m;
    logic [3:0] exp_res;
    logic       exp_c, exp_v, exp_valid;

    rst_n = 1'b0; in_valid = 1'b0; A = '0; B = '0; op = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", obs(), 9'b0_0_0_1_0_0000);
    @(negedge clk);
    rst_n = 1'b1;

    // Operand sweep A=0100, B=0011 across all opcodes, back to back
    drive(1'b1, 4'b0100, 4'b0011, 3'b000); check("sweep_add",  obs(), 9'b1_0_0_0_0_0111);
    drive(1'b1, 4'b0100, 4'b0011, 3'b001); check("sweep_sub",  obs(), 9'b1_0_0_0_0_0001);
    drive(1'b1, 4'b0100, 4'b0011, 3'b010); check("sweep_and",  obs(), 9'b1_0_0_1_0_0000);
    drive(1'b1, 4'b0100, 4'b0011, 3'b011); check("sweep_or",   obs(), 9'b1_0_0_0_0_0111);
    drive(1'b1, 4'b0100, 4'b0011, 3'b100); check("sweep_nota", obs(), 9'b1_0_0_0_1_1011);
    drive(1'b1, 4'b0100, 4'b0011, 3'b101); check("sweep_notb", obs(), 9'b1_0_0_0_1_1100);
    drive(1'b1, 4'b0100, 4'b0011, 3'b110); check("sweep_xor",  obs(), 9'b1_0_0_0_0_0111);
    drive(1'b1, 4'b0100, 4'b0011, 3'b111); check("sweep_xnor", obs(), 9'b1_0_0_0_1_1000);

    // Arithmetic boundaries
    drive(1'b1, 4'b1111, 4'b0001, 3'b000); check("add_carry", obs(), 9'b1_1_0_1_0_0000);
    drive(1'b1, 4'b0111, 4'b0001, 3'b000); check("add_ovf",   obs(), 9'b1_0_1_0_1_1000);
    drive(1'b1, 4'b0011, 4'b0100, 3'b001); check("sub_borrow", obs(), 9'b1_1_0_0_1_1111);
    drive(1'b1, 4'b1000, 4'b0001, 3'b001); check("sub_ovf",   obs(), 9'b1_0_1_0_0_0111);

    // Idle cycles with changing operands must not disturb the held result
    drive(1'b0, 4'b1111, 4'b1111, 3'b000); check("hold_1", obs(), 9'b0_0_1_0_0_0111);
    drive(1'b0, 4'b0000, 4'b0000, 3'b010); check("hold_2", obs(), 9'b0_0_1_0_0_0111);
    drive(1'b0, 4'b1010, 4'b0101, 3'b100); check("hold_3", obs(), 9'b0_0_1_0_0_0111);

    // Asynchronous reset in the middle of a cycle, no clock edge in between
    drive(1'b1, 4'b0011, 4'b0100, 3'b001); check("pre_reset", obs(), 9'b1_1_0_0_1_1111);
    in_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1 check("async_reset", obs(), 9'b0_0_0_1_0_0000);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 4'b0100, 4'b0011, 3'b000); check("post_reset_add", obs(), 9'b1_0_0_0_0_0111);

    // Randomised run against the reference model
    held      = obs();
    exp_res   = held[3:0];
    exp_c     = held[7];
    exp_v     = held[6];
    exp_valid = held[8];
    for (int i = 0; i < 1000; i++) begin
      logic       v;
      logic [3:0] a, b;
      logic [2:0] o;
      v = ($urandom_range(0, 3) != 0);
      a = 4'($urandom_range(0, 15));
      b = 4'($urandom_range(0, 15));
      o = 3'($urandom_range(0, 7));
      drive(v, a, b, o);
      exp_valid = v;
      if (v) begin
        m       = model(a, b, o);
        exp_c   = m[5];
        exp_v   = m[4];
        exp_res = m[3:0];
      end
      check("random", obs(), {exp_valid, exp_c, exp_v, (exp_res == 4'd0), exp_res[3], exp_res});
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
